line_fetch_arbiter: RTL and testbench

LINE_FETCH_ARBITER -- requirements
Module: line_fetch_arbiter

---
 rtl/line_fetch_arbiter_pkg.sv | 21 ++
 rtl/line_fetch_arbiter_if.sv | 31 +++
 rtl/line_fetch_arbiter_write_fifo2.sv | 58 +++++
 rtl/line_fetch_arbiter.sv | 97 +++++++++
 tb/tb_line_fetch_arbiter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/line_fetch_arbiter_pkg.sv
// Shared constants and types for the line fetch arbiter: default widths,
// write buffer depth and the per-cycle memory access kind.
package line_fetch_arbiter_pkg;
  localparam int ADDR_W_DEF       = 16;
  localparam int DATA_W_DEF       = 8;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int FIFO_DEPTH       = 2;

  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } access_e;

  // Starvation counter needs at least 3 bits, more if the limit demands it.
  function automatic int starve_w(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w > 3) ? w : 3;
  endfunction
endpackage

// File: rtl/line_fetch_arbiter_if.sv
// Display read, render write and pixel memory signals of the arbiter.
interface line_fetch_arbiter_if
  import line_fetch_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              dispReq;
  logic [ADDR_W-1:0] dispAddr;
  logic              dispGrant;
  logic              dispValid;
  logic [DATA_W-1:0] dispData;
  logic              rendValid;
  logic [ADDR_W-1:0] rendAddr;
  logic [DATA_W-1:0] rendData;
  logic              rendReady;
  logic [ADDR_W-1:0] memAddr;
  logic              memWe;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] memRdata;

  modport slave (
    input  dispReq, dispAddr, rendValid, rendAddr, rendData, memRdata,
    output dispGrant, dispValid, dispData, rendReady, memAddr, memWe, memWdata
  );

  modport master (
    output dispReq, dispAddr, rendValid, rendAddr, rendData, memRdata,
    input  dispGrant, dispValid, dispData, rendReady, memAddr, memWe, memWdata
  );
endinterface

// File: rtl/line_fetch_arbiter_write_fifo2.sv
// Two-entry render write buffer; ready is registered from next occupancy.
module write_fifo2
  import line_fetch_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  output logic              ready
);
  logic [ADDR_W-1:0] addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] data_q [FIFO_DEPTH];
  logic [1:0]        count;
  logic [1:0]        count_next;
  logic              wr_ptr;
  logic              rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full       = (count == 2'(FIFO_DEPTH));
  assign empty      = (count == 2'd0);
  assign push_ok    = push && !full;
  assign pop_ok     = pop && !empty;
  assign count_next = count + {1'b0, push_ok} - {1'b0, pop_ok};
  assign head_addr  = addr_q[rd_ptr];
  assign head_data  = data_q[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      ready  <= 1'b1;
    end else begin
      count <= count_next;
      ready <= (count_next < 2'(FIFO_DEPTH));
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  end
endmodule

// File: rtl/line_fetch_arbiter.sv
// Single-port pixel memory arbiter: display reads win unless a buffered
// render write has been starved for STARVE_LIMIT consecutive grants.
module line_fetch_arbiter
  import line_fetch_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  line_fetch_arbiter_if.slave  bus
);
  localparam int CNT_W = starve_w(STARVE_LIMIT);

  access_e           access;
  logic [CNT_W-1:0]  starve_cnt;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              ready;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [ADDR_W-1:0] last_addr;
  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;

  assign push = bus.rendValid && ready;
  assign pop  = (access == ACC_WRITE);

  write_fifo2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_addr (bus.rendAddr),
    .push_data (bus.rendData),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .ready     (ready)
  );

  // Stage p0: arbitration and memory request
  always_comb begin
    access = ACC_IDLE;
    if (!reset) begin
      if (!empty && (!bus.dispReq || starve_cnt == CNT_W'(STARVE_LIMIT)))
        access = ACC_WRITE;
      else if (bus.dispReq)
        access = ACC_READ;
    end
  end

  always_comb begin
    bus.memAddr = last_addr;
    case (access)
      ACC_READ:  bus.memAddr = bus.dispAddr;
      ACC_WRITE: bus.memAddr = head_addr;
      default:   bus.memAddr = last_addr;
    endcase
  end

  assign bus.dispGrant = (access == ACC_READ);
  assign bus.memWe     = (access == ACC_WRITE);
  assign bus.memWdata  = head_data;
  assign bus.rendReady = ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_addr  <= '0;
      starve_cnt <= '0;
    end else begin
      if (access != ACC_IDLE) last_addr <= bus.memAddr;
      if (pop || empty)
        starve_cnt <= '0;
      else if (access == ACC_READ && starve_cnt < CNT_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Stage p1: read data returns one cycle after the grant
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= bus.dispGrant;
      if (vld_p1) data_p1 <= bus.memRdata;
    end
  end

  assign bus.dispValid = vld_p1;
  assign bus.dispData  = vld_p1 ? bus.memRdata : data_p1;
endmodule

// File: tb/tb_line_fetch_arbiter.sv
// Directed and randomized bench for line_fetch_arbiter against a queue-based
// reference model of the arbitration and memory contents.
module tb_line_fetch_arbiter;
  localparam int LIMIT = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  line_fetch_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  line_fetch_arbiter #(.ADDR_W(16), .DATA_W(8), .STARVE_LIMIT(LIMIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Pixel memory with one-cycle read latency; unwritten cells hold a pattern.
  logic [7:0] mem [0:65535];
  bit         written [0:65535];

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return 8'(a * 37 + 11);
  endfunction

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    return written[a] ? mem[a] : init_val(a);
  endfunction

  always @(posedge clock) begin
    bus.memRdata <= mem_rd(bus.memAddr);
    if (bus.memWe) begin
      mem[bus.memAddr]     <= bus.memWdata;
      written[bus.memAddr] <= 1'b1;
    end
  end

  // Reference model state
  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t         q[$];
  logic [7:0]  mref[int];
  int          starve_m;
  logic        exp_vld;
  logic [7:0]  exp_data;
  logic        exp_ready;
  logic [15:0] last_addr_m;

  int checks = 0;
  int errors = 0;
  bit obs_gr, obs_we, obs_push, obs_ready, obs_vld;
  logic [7:0] obs_data;
  int nvalid;

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return mref.exists(int'(a)) ? mref[int'(a)] : init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit rst_i, input bit dq, input logic [15:0] da,
                       input bit rv, input logic [15:0] ra, input logic [7:0] rd);
    bit wr, gr, ne, psh;
    logic [15:0] ea;
    @(negedge clock);
    reset         = rst_i;
    bus.dispReq   = dq;
    bus.dispAddr  = da;
    bus.rendValid = rv;
    bus.rendAddr  = ra;
    bus.rendData  = rd;
    #1;
    if (rst_i) begin
      q.delete();
      starve_m    = 0;
      exp_vld     = 1'b0;
      exp_data    = 8'h00;
      exp_ready   = 1'b1;
      last_addr_m = 16'h0000;
      wr = 1'b0;
      gr = 1'b0;
    end else begin
      wr = (q.size() > 0) && (!dq || starve_m == LIMIT);
      gr = dq && !wr;
    end
    ne = (q.size() > 0);
    ea = gr ? da : (wr ? q[0].a : last_addr_m);
    chk("dispGrant", 32'(bus.dispGrant), 32'(gr));
    chk("memWe", 32'(bus.memWe), 32'(wr));
    chk("memAddr", 32'(bus.memAddr), 32'(ea));
    if (wr) chk("memWdata", 32'(bus.memWdata), 32'(q[0].d));
    chk("dispValid", 32'(bus.dispValid), 32'(exp_vld));
    chk("dispData", 32'(bus.dispData), 32'(exp_data));
    chk("rendReady", 32'(bus.rendReady), 32'(exp_ready));
    obs_gr    = bus.dispGrant;
    obs_we    = bus.memWe;
    obs_ready = bus.rendReady;
    obs_vld   = bus.dispValid;
    obs_data  = bus.dispData;
    obs_push  = rv && bus.rendReady && !rst_i;
    if (bus.dispValid) nvalid++;
    if (!rst_i) begin
      psh = rv && exp_ready;
      if (gr) exp_data = ref_rd(da);
      exp_vld = gr;
      if (wr) begin
        mref[int'(q[0].a)] = q[0].d;
        void'(q.pop_front());
      end
      if (wr || !ne) starve_m = 0;
      else if (gr && starve_m < LIMIT) starve_m++;
      if (psh) q.push_back('{a: ra, d: rd});
      exp_ready   = (q.size() < 2);
      last_addr_m = ea;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 8'h00);
  endtask

  initial begin
    int ngr, nwe, tries;
    bit seen;
    bus.dispReq   = 1'b0;
    bus.dispAddr  = '0;
    bus.rendValid = 1'b0;
    bus.rendAddr  = '0;
    bus.rendData  = '0;

    // Reset state
    cycle(1'b1, 1'b1, 16'h7, 1'b1, 16'h1, 8'h11);
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 8'h00);

    // Ten back-to-back display reads, FIFO empty
    nvalid = 0;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 16'(i), 1'b0, 16'h0, 8'h00);
    idle(1);
    chk("valid_count", 32'(nvalid), 32'd10);

    // One write against continuous display traffic: starvation limit
    cycle(1'b0, 1'b1, 16'd100, 1'b1, 16'h0020, 8'hA1);
    ngr  = 0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cycle(1'b0, 1'b1, 16'(101 + k), 1'b0, 16'h0, 8'h00);
      if (!seen) begin
        if (obs_we) seen = 1'b1;
        else if (obs_gr) ngr++;
      end
    end
    chk("starve_grants", 32'(ngr), 32'd4);
    chk("starve_write_seen", 32'(seen), 32'd1);
    idle(2);

    // Three back-to-back pushes while display is busy
    cycle(1'b0, 1'b1, 16'd200, 1'b1, 16'h0030, 8'h01);
    cycle(1'b0, 1'b1, 16'd201, 1'b1, 16'h0031, 8'h02);
    cycle(1'b0, 1'b1, 16'd202, 1'b1, 16'h0030, 8'h03);
    chk("ready_low_after_2", 32'(obs_ready), 32'd0);
    tries = 0;
    while (!obs_push && tries < 20) begin
      cycle(1'b0, 1'b1, 16'(203 + tries), 1'b1, 16'h0030, 8'h03);
      tries++;
    end
    chk("third_push_accepted", 32'(obs_push), 32'd1);
    idle(4);

    // Simultaneous push and pop at occupancy 1
    cycle(1'b0, 1'b0, 16'h0, 1'b1, 16'h0032, 8'h44);
    cycle(1'b0, 1'b0, 16'h0, 1'b1, 16'h0033, 8'h45);
    chk("pushpop_we", 32'(obs_we), 32'd1);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 8'h00);
    chk("pushpop_ready", 32'(obs_ready), 32'd1);
    idle(2);

    // Read of an address with a buffered write returns the old value
    cycle(1'b0, 1'b0, 16'h0, 1'b1, 16'h0040, 8'h55);
    cycle(1'b0, 1'b1, 16'h0040, 1'b0, 16'h0, 8'h00);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 8'h00);
    chk("raw_old_valid", 32'(obs_vld), 32'd1);
    chk("raw_old_data", 32'(obs_data), 32'(init_val(16'h0040)));
    cycle(1'b0, 1'b1, 16'h0040, 1'b0, 16'h0, 8'h00);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 8'h00);
    chk("raw_new_data", 32'(obs_data), 32'h55);

    // Reset with two writes buffered and a read in flight
    cycle(1'b0, 1'b1, 16'd5, 1'b1, 16'h0050, 8'hAA);
    cycle(1'b0, 1'b1, 16'd6, 1'b1, 16'h0051, 8'hBB);
    cycle(1'b1, 1'b1, 16'd7, 1'b0, 16'h0, 8'h00);
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 8'h00);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 8'h00);
    chk("post_reset_valid", 32'(obs_vld), 32'd0);
    chk("post_reset_ready", 32'(obs_ready), 32'd1);
    nwe = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 8'h00);
      if (obs_we) nwe++;
    end
    chk("post_reset_no_we", 32'(nwe), 32'd0);

    // Randomized traffic on a small address window to force hazards
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 100) == 0, ($urandom % 3) != 0, 16'($urandom % 16),
            ($urandom % 2) == 1, 16'($urandom % 16), 8'($urandom));
    end
    idle(6);

    // Final memory image against the model
    for (int a = 0; a < 16'h0060; a++) chk("mem_image", 32'(mem_rd(16'(a))), 32'(ref_rd(16'(a))));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
